mod_reduce_66: RTL and testbench
================================

# mod_reduce_66

Sequential modular reducer that takes the 66-bit product stream from the 34x34 Karatsuba multiplier and returns the 34-bit remainder modulo a runtime modulus. It is the consumer end of the multiplier's output stream in the ElGamal datapath. Every modular multiply is the pair multiplier -> mod_reduce_66. Restoring shift-subtract, one dividend bit per clock, with valid/ready handshakes on both sides.

## Interface
- DIVIDEND_W, 66, product width
- MOD_W, 34, modulus/remainder width
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- input_a_tdata  input  DIVIDEND_W  dividend (product)
- input_a_tvalid  input  1  dividend valid
- input_a_tready  output  1  dividend accepted
- input_b_tdata  input  MOD_W  modulus
- input_b_tvalid  input  1  modulus valid
- input_b_tready  output  1  modulus accepted
- output_tdata  output  MOD_W  remainder
- output_tvalid  output  1  remainder valid
- output_tready  input  1  downstream ready
- output_q_tdata  output  DIVIDEND_W  quotient; present only with MOD_REDUCE_QUOTIENT_EN

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - input_a_tready = input_b_tvalid; input_b_tready = input_a_tvalid.
  - Both inputs transfer on the same edge, when both valids are high.
  - On transfer, latch the dividend into the shift register, the modulus into mod_reg, and clear the partial remainder (MOD_W+1 bits).
  - Counter loads DIVIDEND_W-1.
  - Go to CALC, or go directly to DONE if the modulus is 0.
- CALC, one step per cycle:
  - r' = {r[MOD_W-1:0], dividend MSB}; shift the dividend left.
  - If r' >= mod_reg: r = r' - mod_reg and quotient bit = 1. Otherwise r = r' and quotient bit = 0.
  - At counter 0 go to DONE; otherwise decrement.
- DONE:
  - output_tvalid = 1; output_tdata = r[MOD_W-1:0].
  - On output_tvalid & output_tready go to IDLE.
- Both treadys are 0 outside IDLE. No input is accepted in the same cycle as an output handshake.
- Width rule: the partial remainder is MOD_W+1 bits, because r' < 2*mod. The remainder is always < mod_reg.
- Modulus 0: remainder 0, quotient all ones; no CALC cycles.
- Dividend < modulus needs no special case; the remainder equals the dividend.

## Timing
- Reset values:
  - state IDLE
  - output_tvalid 0, output_tdata 0, output_q_tdata 0
  - input_a_tready 0, input_b_tready 0 (asserted in IDLE only when the other valid is high)
- Latency: input handshake on edge E0, CALC on edges E1..E66, output_tvalid high after E66. This is 66 edges; with modulus 0 it is 1 edge.
- Minimum interval between accepted operands is 68 cycles (66 CALC + DONE + IDLE).
- Backpressure: output_tdata and output_tvalid hold stable in DONE until output_tready. Indefinite stall is legal.
- Reset during CALC or DONE aborts the operation: state IDLE, output_tvalid 0 on the next edge. The aborted result is never presented.
- Changing input data while tvalid is low, or outside IDLE, has no effect.

## Configuration
- MOD_REDUCE_QUOTIENT_EN defined:
  - A DIVIDEND_W quotient register fills from the dividend shift-out positions.
  - output_q_tdata is valid with output_tvalid.
- MOD_REDUCE_QUOTIENT_EN not defined: the port and the register are absent. Remainder behaviour is identical.

## Structure
- Shared package elgamal_pkg holds:
  - DIVIDEND_W and MOD_W constants
  - typedef for the FSM state (IDLE/CALC/DONE)
  - counter width ($clog2(DIVIDEND_W))
- Sub-module mod_reduce_step is the combinational single-bit shift-compare-subtract. Inputs: r, incoming bit, mod. Outputs: r_next, q_bit. It is reusable for a later multi-step (radix-4) variant.

## Test plan
- 100 mod 7 -> output_tdata 2 (q 14); output_tvalid exactly 66 edges after the handshake.
- 83810205 (12345*6789) mod 1000003 -> 809956; 5 mod 9 -> 5; any value mod 1 -> 0.
- 2^66-1 mod 2^34-1 -> 34'h0FFFFFFFF (q checked with the macro on).
- Modulus 0 with dividend 66'h123 -> remainder 0 (q all ones), valid 1 edge after accept.
- Backpressure:
  - Hold output_tready low 10 cycles in DONE -> data and valid stable, both treadys 0.
  - A new operand pair held valid is accepted only on the edge after IDLE re-entry.
- Assert rst at CALC step 30 -> output_tvalid 0 and IDLE; a following 100 mod 7 returns 2 with nominal latency.

Source files
------------

// File: rtl/elgamal_pkg.sv
// Shared constants and FSM state type for the ElGamal modular datapath.
package elgamal_pkg;

   localparam int DIVIDEND_W = 66;
   localparam int MOD_W      = 34;
   localparam int CNT_W      = $clog2(DIVIDEND_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mod_reduce_step.sv
// One restoring shift-compare-subtract step: shift in one dividend bit, subtract mod if it fits.
module mod_reduce_step
   import elgamal_pkg::*;
(
   input  logic [MOD_W:0]   r,
   input  logic             bit_in,
   input  logic [MOD_W-1:0] mod,
   output logic [MOD_W:0]   r_next,
   output logic             q_bit
);

   logic [MOD_W+1:0] r_shift;
   logic [MOD_W:0]   r_sub;

   // r < mod always holds, so the shifted value is < 2*mod and the difference fits MOD_W+1 bits.
   always_comb begin
      r_shift = {r, bit_in};
      q_bit   = (r_shift >= {2'b00, mod});
      r_sub   = r_shift[MOD_W:0] - {1'b0, mod};
      r_next  = q_bit ? r_sub : r_shift[MOD_W:0];
   end

endmodule

// File: rtl/mod_reduce_66.sv
// Sequential 66-bit by 34-bit modular reducer, one dividend bit per clock.
// Optional quotient output enabled by defining MOD_REDUCE_QUOTIENT_EN.
module mod_reduce_66
   import elgamal_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIVIDEND_W-1:0] input_a_tdata,
   input  logic                  input_a_tvalid,
   output logic                  input_a_tready,
   input  logic [MOD_W-1:0]      input_b_tdata,
   input  logic                  input_b_tvalid,
   output logic                  input_b_tready,
   output logic [MOD_W-1:0]      output_tdata,
   output logic                  output_tvalid,
   input  logic                  output_tready
`ifdef MOD_REDUCE_QUOTIENT_EN
   ,
   output logic [DIVIDEND_W-1:0] output_q_tdata
`endif
);

`ifdef MOD_REDUCE_QUOTIENT_EN
   localparam logic QUOTIENT_EN = 1'b1;
`else
   localparam logic QUOTIENT_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

   state_t                state_reg, state_next;
   logic [MOD_W:0]        r_reg, r_next;
   logic [DIVIDEND_W-1:0] div_reg, div_next;
   logic [MOD_W-1:0]      mod_reg, mod_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [MOD_W:0]        step_r;
   logic                  step_q;

   mod_reduce_step u_step (
      .r      (r_reg),
      .bit_in (div_reg[DIVIDEND_W-1]),
      .mod    (mod_reg),
      .r_next (step_r),
      .q_bit  (step_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         r_reg     <= '0;
         div_reg   <= '0;
         mod_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         div_reg   <= div_next;
         mod_reg   <= mod_next;
         cnt_reg   <= cnt_next;
      end
   end

   // The dividend register doubles as the quotient register: quotient bits enter
   // at the LSB as dividend bits leave at the MSB.
   always_comb begin
      state_next     = state_reg;
      r_next         = r_reg;
      div_next       = div_reg;
      mod_next       = mod_reg;
      cnt_next       = cnt_reg;
      input_a_tready = 1'b0;
      input_b_tready = 1'b0;
      output_tvalid  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            input_a_tready = input_b_tvalid;
            input_b_tready = input_a_tvalid;
            if (input_a_tvalid && input_b_tvalid) begin
               mod_next = input_b_tdata;
               r_next   = '0;
               cnt_next = CNT_LAST;
               if (input_b_tdata == '0) begin
                  div_next   = QUOTIENT_EN ? '1 : input_a_tdata;
                  state_next = DONE;
               end else begin
                  div_next   = input_a_tdata;
                  state_next = CALC;
               end
            end
         end
         CALC: begin
            r_next   = step_r;
            div_next = {div_reg[DIVIDEND_W-2:0], step_q & QUOTIENT_EN};
            if (cnt_reg == '0) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         DONE: begin
            output_tvalid = 1'b1;
            if (output_tready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign output_tdata = r_reg[MOD_W-1:0];

`ifdef MOD_REDUCE_QUOTIENT_EN
   assign output_q_tdata = div_reg;
`endif

endmodule

// File: tb/tb_mod_reduce_66.sv
// Randomized and directed checks of mod_reduce_66 against an arithmetic reference model.
module tb_mod_reduce_66;
   import elgamal_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [DIVIDEND_W-1:0] a_data = '0;
   logic                  a_valid = 1'b0;
   logic                  input_a_tready;
   logic [MOD_W-1:0]      b_data = '0;
   logic                  b_valid = 1'b0;
   logic                  input_b_tready;
   logic [MOD_W-1:0]      output_tdata;
   logic                  output_tvalid;
   logic                  out_ready = 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
   logic [DIVIDEND_W-1:0] output_q_tdata;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mod_reduce_66 dut (
      .clk            (clk),
      .rst            (rst),
      .input_a_tdata  (a_data),
      .input_a_tvalid (a_valid),
      .input_a_tready (input_a_tready),
      .input_b_tdata  (b_data),
      .input_b_tvalid (b_valid),
      .input_b_tready (input_b_tready),
      .output_tdata   (output_tdata),
      .output_tvalid  (output_tvalid),
      .output_tready  (out_ready)
`ifdef MOD_REDUCE_QUOTIENT_EN
      ,
      .output_q_tdata (output_q_tdata)
`endif
   );

   task automatic check_val(input string tag, input logic [DIVIDEND_W-1:0] got,
                            input logic [DIVIDEND_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MOD_W-1:0] ref_rem(input logic [DIVIDEND_W-1:0] a,
                                                input logic [MOD_W-1:0] b);
      logic [DIVIDEND_W-1:0] bw;
      bw = DIVIDEND_W'(b);
      if (b == '0) return '0;
      return MOD_W'(a % bw);
   endfunction

   function automatic logic [DIVIDEND_W-1:0] ref_quo(input logic [DIVIDEND_W-1:0] a,
                                                     input logic [MOD_W-1:0] b);
      logic [DIVIDEND_W-1:0] bw;
      bw = DIVIDEND_W'(b);
      if (b == '0) return '1;
      return a / bw;
   endfunction

   // Runs one operation; stall = cycles of output backpressure, hold = present the
   // next pair (100 mod 7) during the output handshake and leave it valid.
   task automatic run_op(input logic [DIVIDEND_W-1:0] a, input logic [MOD_W-1:0] b,
                         input int stall, input bit hold, input string tag);
      logic [MOD_W-1:0] exp_r;
      int               lat;
      bit               got_rdy;
      exp_r = ref_rem(a, b);
      @(negedge clk);
      a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b0;
      got_rdy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (input_a_tready && input_b_tready) begin
            got_rdy = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val({tag, "_accept"}, DIVIDEND_W'(got_rdy), 1);
      if (!got_rdy) begin
         a_valid = 1'b0; b_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0;
      a_data[31:0] = $urandom; b_data[31:0] = $urandom;
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         if (output_tvalid) begin
            lat = n;
            break;
         end
         @(posedge clk);
         #1;
      end
      check_val({tag, "_latency"}, DIVIDEND_W'(lat), (b == '0) ? 0 : 66);
      check_val({tag, "_rem"}, DIVIDEND_W'(output_tdata), DIVIDEND_W'(exp_r));
`ifdef MOD_REDUCE_QUOTIENT_EN
      check_val({tag, "_quo"}, output_q_tdata, ref_quo(a, b));
`endif
      if (stall > 0) begin
         a_valid = 1'b1; b_valid = 1'b1;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_val({tag, "_stall_valid"}, DIVIDEND_W'(output_tvalid), 1);
            check_val({tag, "_stall_data"}, DIVIDEND_W'(output_tdata), DIVIDEND_W'(exp_r));
            check_val({tag, "_stall_ready"}, DIVIDEND_W'({input_a_tready, input_b_tready}), 0);
         end
         a_valid = 1'b0; b_valid = 1'b0;
      end
      @(negedge clk);
      out_ready = 1'b1;
      if (hold) begin
         a_data = 66'd100; b_data = 34'd7; a_valid = 1'b1; b_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val({tag, "_vld_drop"}, DIVIDEND_W'(output_tvalid), 0);
      if (hold) begin
         check_val({tag, "_reentry_ready"}, DIVIDEND_W'({input_a_tready, input_b_tready}), 3);
      end
   endtask

   initial begin
      logic [DIVIDEND_W-1:0] ra;
      logic [MOD_W-1:0]      rb;
      int                    seen;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_tvalid", DIVIDEND_W'(output_tvalid), 0);
      check_val("rst_tdata", DIVIDEND_W'(output_tdata), 0);
      check_val("rst_treadys", DIVIDEND_W'({input_a_tready, input_b_tready}), 0);
`ifdef MOD_REDUCE_QUOTIENT_EN
      check_val("rst_qdata", output_q_tdata, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      a_valid = 1'b1;
      #1;
      check_val("idle_b_ready_only", DIVIDEND_W'({input_a_tready, input_b_tready}), 1);
      a_valid = 1'b0;

      run_op(66'd100, 34'd7, 0, 1'b0, "m100_7");
      run_op(66'd83810205, 34'd1000003, 0, 1'b0, "big_prime");
      run_op(66'd5, 34'd9, 0, 1'b0, "small_div");
      run_op(66'h2_DEAD_BEEF_1234_5678, 34'd1, 0, 1'b0, "mod_one");
      run_op({DIVIDEND_W{1'b1}}, {MOD_W{1'b1}}, 0, 1'b0, "all_ones");
      run_op(66'h123, 34'd0, 0, 1'b0, "mod_zero");
      run_op(66'd83810205, 34'd1000003, 10, 1'b0, "bp_stall");
      run_op(66'd5, 34'd9, 3, 1'b1, "bp_hold");
      run_op(66'd100, 34'd7, 0, 1'b0, "after_hold");

      // Reset in the middle of a computation must discard it.
      @(negedge clk);
      a_data = 66'd1000; b_data = 34'd3; a_valid = 1'b1; b_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("abort_tvalid", DIVIDEND_W'(output_tvalid), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (output_tvalid) seen++;
      end
      check_val("abort_no_result", DIVIDEND_W'(seen), 0);
      a_valid = 1'b1;
      #1;
      check_val("abort_idle", DIVIDEND_W'({input_a_tready, input_b_tready}), 1);
      a_valid = 1'b0;
      run_op(66'd100, 34'd7, 0, 1'b0, "post_rst");

      for (int i = 0; i < 25; i++) begin
         ra[31:0]  = $urandom;
         ra[63:32] = $urandom;
         ra[65:64] = 2'($urandom);
         case ($urandom_range(0, 3))
            0: rb = MOD_W'($urandom_range(1, 16));
            1: begin
               rb[31:0]  = $urandom;
               rb[33:32] = 2'($urandom);
            end
            2: rb = MOD_W'($urandom);
            default: begin
               rb[31:0]  = $urandom;
               rb[33:32] = 2'b11;
               ra = DIVIDEND_W'(rb >> $urandom_range(0, 3));
            end
         endcase
         run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
